// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, register ids, bubble values.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fetch_stage_pkg;

  // Instruction codes (byte0[7:4])
  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Pipeline status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // "No register" id
  localparam logic [3:0] RNONE = 4'hF;

  // Values loaded into D for a bubble (looks like a harmless nop)
  localparam logic [2:0]  BUBBLE_STAT  = STAT_AOK;
  localparam logic [3:0]  BUBBLE_ICODE = ICODE_NOP;
  localparam logic [3:0]  BUBBLE_IFUN  = 4'h0;
  localparam logic [3:0]  BUBBLE_RA    = RNONE;
  localparam logic [3:0]  BUBBLE_RB    = RNONE;
  localparam logic [63:0] BUBBLE_VALC  = 64'd0;
  localparam logic [63:0] BUBBLE_VALP  = 64'd0;

  // Instruction carries a register-specifier byte
  function automatic logic needs_regids(input logic [3:0] icode);
    return (icode == ICODE_RRMOVQ) || (icode == ICODE_IRMOVQ) ||
           (icode == ICODE_RMMOVQ) || (icode == ICODE_MRMOVQ) ||
           (icode == ICODE_OPQ)    || (icode == ICODE_PUSHQ)  ||
           (icode == ICODE_POPQ);
  endfunction

  // Instruction carries an 8-byte constant
  function automatic logic needs_valc(input logic [3:0] icode);
    return (icode == ICODE_IRMOVQ) || (icode == ICODE_RMMOVQ) ||
           (icode == ICODE_MRMOVQ) || (icode == ICODE_JXX)    ||
           (icode == ICODE_CALL);
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Splits a 10-byte fetch window into Y86-64 fields, computes valP/predPC and fetch status.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing stage decides whether the result is captured.
module fetch_decode
  import fetch_stage_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [79:0] i_imem_data,
  input  logic [63:0] i_f_pc,
  output logic [3:0]  o_icode,
  output logic [3:0]  o_ifun,
  output logic [3:0]  o_ra,
  output logic [3:0]  o_rb,
  output logic [63:0] o_valc,
  output logic [63:0] o_valp,
  output logic [63:0] o_predpc,
  output logic [2:0]  o_f_stat
);

  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_need_regids;
  logic        w_need_valc;
  logic [3:0]  w_len;
  logic [64:0] w_end_addr;
  logic        w_imem_error;
  logic        w_instr_valid;
  logic [63:0] w_valc;
  logic [63:0] w_valp;

  assign w_icode       = i_imem_data[7:4];
  assign w_ifun        = i_imem_data[3:0];
  assign w_need_regids = needs_regids(w_icode);
  assign w_need_valc   = needs_valc(w_icode);

  // Instruction length in bytes: 1, 2, 9 or 10
  assign w_len = 4'd1 + {3'b000, w_need_regids} + (w_need_valc ? 4'd8 : 4'd0);

  // Widened to 65 bits so a PC near 2^64 cannot wrap past the memory limit
  assign w_end_addr   = {1'b0, i_f_pc} + {61'd0, w_len};
  assign w_imem_error = (w_end_addr > 65'(IMEM_BYTES));

  // Constant starts right after the register byte when there is one; little-endian
  assign w_valc = !w_need_valc   ? 64'd0 :
                  w_need_regids  ? i_imem_data[79:16] :
                                   i_imem_data[71:8];

  assign w_valp = i_f_pc + {60'd0, w_len};

  // Legal icode/ifun combinations
  always_comb begin
    w_instr_valid = 1'b0;
    case (w_icode)
      ICODE_RRMOVQ, ICODE_JXX: w_instr_valid = (w_ifun <= 4'd6);
      ICODE_OPQ:               w_instr_valid = (w_ifun <= 4'd3);
      ICODE_HALT, ICODE_NOP, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:
                               w_instr_valid = (w_ifun == 4'd0);
      default:                 w_instr_valid = 1'b0;
    endcase
  end

  // Status priority: address error beats illegal instruction beats halt
  always_comb begin
    o_f_stat = STAT_AOK;
    if (w_imem_error)              o_f_stat = STAT_ADR;
    else if (!w_instr_valid)       o_f_stat = STAT_INS;
    else if (w_icode == ICODE_HALT) o_f_stat = STAT_HLT;
  end

  assign o_icode  = w_icode;
  assign o_ifun   = w_ifun;
  assign o_ra     = w_need_regids ? i_imem_data[15:12] : RNONE;
  assign o_rb     = w_need_regids ? i_imem_data[11:8]  : RNONE;
  assign o_valc   = w_valc;
  assign o_valp   = w_valp;
  // Jumps and calls are predicted taken
  assign o_predpc = (w_icode == ICODE_JXX || w_icode == ICODE_CALL) ? w_valc : w_valp;

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch: PC select, F predicted-PC register, sticky halted flag and D pipeline register.
// Latency: fields for the PC on imem_addr appear on D_* one clock later.
// Backpressure: F_stall holds F, D_stall holds D (wins over D_bubble); halted fetch feeds bubbles.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        f_halted
);

  logic [63:0] r_pred_pc;
  logic        r_halted;
  logic [2:0]  r_d_stat;
  logic [3:0]  r_d_icode;
  logic [3:0]  r_d_ifun;
  logic [3:0]  r_d_ra;
  logic [3:0]  r_d_rb;
  logic [63:0] r_d_valc;
  logic [63:0] r_d_valp;

  logic        w_mispredict;
  logic        w_ret;
  logic        w_repair;
  logic [63:0] w_f_pc;
  logic        w_fetch_active;
  logic        w_enter_d;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [63:0] w_valc;
  logic [63:0] w_valp;
  logic [63:0] w_predpc;
  logic [2:0]  w_f_stat;

  assign w_mispredict = (M_icode == ICODE_JXX) && !M_Cnd;
  assign w_ret        = (W_icode == ICODE_RET);
  assign w_repair     = w_mispredict || w_ret;

  // PC select: mispredict repair first, then ret target, else prediction
  assign w_f_pc = w_mispredict ? M_valA :
                  w_ret        ? W_valM :
                                 r_pred_pc;

  // A repair re-opens fetch even after a wrong-path halt
  assign w_fetch_active = !r_halted || w_repair;
  assign w_enter_d      = w_fetch_active && !D_stall && !D_bubble;

  fetch_decode #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_decode (
    .i_imem_data (imem_data),
    .i_f_pc      (w_f_pc),
    .o_icode     (w_icode),
    .o_ifun      (w_ifun),
    .o_ra        (w_ra),
    .o_rb        (w_rb),
    .o_valc      (w_valc),
    .o_valp      (w_valp),
    .o_predpc    (w_predpc),
    .o_f_stat    (w_f_stat)
  );

  // F register: advance the predicted PC unless stalled or halted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pred_pc <= RESET_PC;
    end else if (!F_stall && w_fetch_active) begin
      r_pred_pc <= w_predpc;
    end
  end

  // Halted flag: set when a non-AOK instruction enters D; a repair clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_halted <= 1'b0;
    end else if (!F_stall) begin
      if (w_repair) begin
        r_halted <= w_enter_d && (w_f_stat != STAT_AOK);
      end else if (w_enter_d && (w_f_stat != STAT_AOK)) begin
        r_halted <= 1'b1;
      end
    end
  end

  // D register: stall holds, bubble (or halted fetch) inserts a nop, else capture fetch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d_stat  <= BUBBLE_STAT;
      r_d_icode <= BUBBLE_ICODE;
      r_d_ifun  <= BUBBLE_IFUN;
      r_d_ra    <= BUBBLE_RA;
      r_d_rb    <= BUBBLE_RB;
      r_d_valc  <= BUBBLE_VALC;
      r_d_valp  <= BUBBLE_VALP;
    end else if (D_stall) begin
      r_d_stat  <= r_d_stat;
    end else if (!w_enter_d) begin
      r_d_stat  <= BUBBLE_STAT;
      r_d_icode <= BUBBLE_ICODE;
      r_d_ifun  <= BUBBLE_IFUN;
      r_d_ra    <= BUBBLE_RA;
      r_d_rb    <= BUBBLE_RB;
      r_d_valc  <= BUBBLE_VALC;
      r_d_valp  <= BUBBLE_VALP;
    end else begin
      r_d_stat  <= w_f_stat;
      r_d_icode <= w_icode;
      r_d_ifun  <= w_ifun;
      r_d_ra    <= w_ra;
      r_d_rb    <= w_rb;
      r_d_valc  <= w_valc;
      r_d_valp  <= w_valp;
    end
  end

  assign imem_addr = w_f_pc;
  assign D_stat    = r_d_stat;
  assign D_icode   = r_d_icode;
  assign D_ifun    = r_d_ifun;
  assign D_rA      = r_d_ra;
  assign D_rB      = r_d_rb;
  assign D_valC    = r_d_valc;
  assign D_valP    = r_d_valp;
  assign f_halted  = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-array instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rstn;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        f_halted;

  logic [7:0] mem [0:1023];
  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_stage #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_data(imem_data),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .f_halted(f_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: bytes beyond the array read as zero
  always_comb begin
    imem_data = 80'd0;
    for (int i = 0; i < 10; i++) begin
      if (imem_addr + 64'(i) < 64'd1024)
        imem_data[i*8 +: 8] = mem[10'(imem_addr + 64'(i))];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    F_stall = 0; D_stall = 0; D_bubble = 0;
    M_icode = 4'h1; M_Cnd = 0; M_valA = 0;
    W_icode = 4'h1; W_valM = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset imem_addr", imem_addr, 64'd0);
    chk("reset D_icode", 64'(D_icode), 64'h1);
    chk("reset D_rA", 64'(D_rA), 64'hF);
    chk("reset D_rB", 64'(D_rB), 64'hF);
    chk("reset D_stat", 64'(D_stat), 64'd1);
    chk("reset f_halted", 64'(f_halted), 64'd0);
  endtask

  task automatic test_irmovq();
    do_reset();
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    tick();
    chk("irmovq D_icode", 64'(D_icode), 64'h3);
    chk("irmovq D_rA", 64'(D_rA), 64'hF);
    chk("irmovq D_rB", 64'(D_rB), 64'h2);
    chk("irmovq D_valC", D_valC, 64'hA);
    chk("irmovq D_valP", D_valP, 64'hA);
    chk("irmovq imem_addr", imem_addr, 64'hA);
    chk("irmovq D_stat", 64'(D_stat), 64'd1);
  endtask

  task automatic test_mispredict_ret();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h10;
    mem[16] = 8'h74; mem[17] = 8'h40;
    mem[8'h19] = 8'h10;
    repeat (17) tick();
    chk("jne D_icode", 64'(D_icode), 64'h7);
    chk("jne D_ifun", 64'(D_ifun), 64'h4);
    chk("jne D_valC", D_valC, 64'h40);
    chk("jne D_valP", D_valP, 64'h19);
    chk("jne predicted addr", imem_addr, 64'h40);
    M_icode = 4'h7; M_Cnd = 1'b1; M_valA = 64'h19; #1;
    chk("taken jne keeps prediction", imem_addr, 64'h40);
    M_Cnd = 1'b0; #1;
    chk("mispredict addr", imem_addr, 64'h19);
    W_icode = 4'h9; W_valM = 64'h80; #1;
    chk("mispredict beats ret", imem_addr, 64'h19);
    M_icode = 4'h1; #1;
    chk("ret addr", imem_addr, 64'h80);
    W_icode = 4'h1; M_icode = 4'h7; M_Cnd = 1'b0;
    tick();
    M_icode = 4'h1; #1;
    chk("after repair D_valP", D_valP, 64'h1A);
    chk("after repair addr", imem_addr, 64'h1A);
  endtask

  task automatic test_stall_bubble();
    do_reset();
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    mem[10] = 8'h20; mem[11] = 8'h12; mem[12] = 8'h10; mem[13] = 8'h10;
    tick();
    D_stall = 1; F_stall = 1;
    tick();
    tick();
    chk("D_stall D_icode", 64'(D_icode), 64'h3);
    chk("D_stall D_valP", D_valP, 64'hA);
    chk("F_stall addr", imem_addr, 64'hA);
    D_stall = 0; F_stall = 0;
    tick();
    chk("rrmovq D_icode", 64'(D_icode), 64'h2);
    chk("rrmovq D_rA", 64'(D_rA), 64'h1);
    chk("rrmovq D_rB", 64'(D_rB), 64'h2);
    chk("rrmovq D_valP", D_valP, 64'hC);
    D_stall = 1; D_bubble = 1;
    tick();
    chk("stall beats bubble", 64'(D_icode), 64'h2);
    D_stall = 0;
    tick();
    chk("bubble D_icode", 64'(D_icode), 64'h1);
    chk("bubble D_rA", 64'(D_rA), 64'hF);
    chk("bubble D_valP", D_valP, 64'd0);
    D_bubble = 0;
  endtask

  task automatic test_halt();
    do_reset();
    mem[8'h20] = 8'h20; mem[8'h21] = 8'h34;
    tick();
    chk("halt D_stat", 64'(D_stat), 64'd2);
    chk("halt f_halted", 64'(f_halted), 64'd1);
    chk("halt addr", imem_addr, 64'd1);
    repeat (3) tick();
    chk("halted addr constant", imem_addr, 64'd1);
    chk("halted D_icode bubble", 64'(D_icode), 64'h1);
    W_icode = 4'h9; W_valM = 64'h20; #1;
    chk("halted ret addr", imem_addr, 64'h20);
    tick();
    W_icode = 4'h1; #1;
    chk("repair D_icode", 64'(D_icode), 64'h2);
    chk("repair clears halted", 64'(f_halted), 64'd0);
    chk("repair addr", imem_addr, 64'h22);
    rstn = 1'b0; #1;
    chk("async reset D_icode", 64'(D_icode), 64'h1);
    chk("async reset addr", imem_addr, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_ins_adr();
    do_reset();
    mem[0] = 8'hC0;
    tick();
    chk("icode C D_stat", 64'(D_stat), 64'd4);
    do_reset();
    mem[0] = 8'h64; mem[1] = 8'h12;
    tick();
    chk("opq ifun4 D_stat", 64'(D_stat), 64'd4);
    do_reset();
    mem[0] = 8'h63; mem[1] = 8'h12;
    tick();
    chk("opq ifun3 D_stat", 64'(D_stat), 64'd1);
    chk("opq ifun3 halted", 64'(f_halted), 64'd0);
    do_reset();
    mem[1022] = 8'h30; mem[1023] = 8'hF2;
    W_icode = 4'h9; W_valM = 64'd1022;
    tick();
    W_icode = 4'h1;
    chk("irmovq at 1022 D_stat", 64'(D_stat), 64'd3);
    do_reset();
    mem[1014] = 8'h30; mem[1015] = 8'hF2; mem[1016] = 8'h07;
    W_icode = 4'h9; W_valM = 64'd1014;
    tick();
    W_icode = 4'h1;
    chk("irmovq at 1014 D_stat", 64'(D_stat), 64'd1);
    chk("irmovq at 1014 D_valP", D_valP, 64'd1024);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    #1;
    test_reset();
    test_irmovq();
    test_mispredict_ret();
    test_stall_bubble();
    test_halt();
    test_ins_adr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
